issue_replay_buffer: RTL and testbench

ISSUE_REPLAY_BUFFER -- requirements
Module: issue_replay_buffer

---
 rtl/issue_replay_buffer.sv | 153 +++++++++++++++
 tb/tb_issue_replay_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_replay_buffer.sv
// Issue replay buffer: circular IF->ID queue presenting the oldest three entries and replaying rejected ways.
// Optional same-cycle bypass from empty is enabled by defining REPLAY_BUFFER_BYPASS_EN.
package issue_replay_buffer_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } IF_ID_PACKET;
endpackage

module issue_replay_buffer
  import issue_replay_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  IF_ID_PACKET               if_packet_0,
  input  IF_ID_PACKET               if_packet_1,
  input  IF_ID_PACKET               if_packet_2,
  input  logic [1:0]                rollback,
  input  logic                      stall,
  input  logic                      squash,
  output logic                      fetch_ready,
  output IF_ID_PACKET               id_packet_out_0,
  output IF_ID_PACKET               id_packet_out_1,
  output IF_ID_PACKET               id_packet_out_2,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  IF_ID_PACKET            r_mem [DEPTH];
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [CNT_W-1:0]       r_occ;

  IF_ID_PACKET            w_in      [3];
  IF_ID_PACKET            w_out     [3];
  IF_ID_PACKET            w_wr_data [3];
  logic [PTR_W-1:0]       w_rd_idx  [3];
  logic [1:0]             w_in_cnt;
  logic [1:0]             w_out_cnt;
  logic [1:0]             w_accept;
  logic [1:0]             w_deq;
  logic [1:0]             w_enq;
  logic [1:0]             w_wr_base;
  logic                   w_bypass;

  // A rollback larger than the presented count rejects everything.
  function automatic logic [1:0] accept_cnt(input logic [1:0] cnt, input logic [1:0] rb);
    logic [1:0] room;
    room = 2'd3 - rb;
    if (rb > cnt) return 2'd0;
    return (cnt < room) ? cnt : room;
  endfunction

  assign w_in[0] = if_packet_0;
  assign w_in[1] = if_packet_1;
  assign w_in[2] = if_packet_2;

  always_comb begin
    w_in_cnt = 2'd0;
    if (if_packet_0.valid) begin
      w_in_cnt = 2'd1;
      if (if_packet_1.valid) begin
        w_in_cnt = 2'd2;
        if (if_packet_2.valid) w_in_cnt = 2'd3;
      end
    end
  end

  assign w_out_cnt   = (r_occ >= CNT_W'(3)) ? 2'd3 : r_occ[1:0];
  assign fetch_ready = (r_occ <= CNT_W'(DEPTH - 3));
  assign occupancy   = r_occ;

`ifdef REPLAY_BUFFER_BYPASS_EN
  assign w_bypass = (r_occ == '0) && !squash && !reset;
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    w_accept  = accept_cnt(w_bypass ? w_in_cnt : w_out_cnt, rollback);
    w_deq     = 2'd0;
    w_enq     = 2'd0;
    w_wr_base = 2'd0;
    if (!squash) begin
      if (w_bypass) begin
        // Accepted ways went straight to ID; only the remainder is stored.
        w_wr_base = stall ? 2'd0 : w_accept;
        w_enq     = w_in_cnt - w_wr_base;
      end else begin
        if (fetch_ready) w_enq = w_in_cnt;
        if (!stall)      w_deq = w_accept;
      end
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_way
    logic [2:0] w_src_idx;
    assign w_src_idx = {1'b0, w_wr_base} + 3'(gi);
    assign w_rd_idx[gi] = r_head + PTR_W'(gi);

    always_comb begin
      case (w_src_idx)
        3'd0:    w_wr_data[gi] = w_in[0];
        3'd1:    w_wr_data[gi] = w_in[1];
        3'd2:    w_wr_data[gi] = w_in[2];
        default: w_wr_data[gi] = '0;
      endcase
    end

    always_comb begin
      w_out[gi] = '0;
      if (w_bypass) begin
        if (w_in[gi].valid) w_out[gi] = w_in[gi];
      end else if (r_occ > CNT_W'(gi)) begin
        w_out[gi]       = r_mem[w_rd_idx[gi]];
        w_out[gi].valid = 1'b1;
      end
    end
  end

  assign id_packet_out_0 = w_out[0];
  assign id_packet_out_1 = w_out[1];
  assign id_packet_out_2 = w_out[2];

  always_ff @(posedge clock) begin
    for (int j = 0; j < 3; j++) begin
      if (w_enq > 2'(j)) r_mem[r_tail + PTR_W'(j)] <= w_wr_data[j];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (squash) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      r_head <= r_head + PTR_W'(w_deq);
      r_tail <= r_tail + PTR_W'(w_enq);
      r_occ  <= r_occ + CNT_W'(w_enq) - CNT_W'(w_deq);
    end
  end

endmodule

// File: tb/tb_issue_replay_buffer.sv
// Scoreboard bench for issue_replay_buffer: expected PCs queued on enqueue, popped as ID accepts them.
module tb_issue_replay_buffer;
  import issue_replay_buffer_pkg::*;

  localparam int DEPTH = 8;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  IF_ID_PACKET            tb_in  [3];
  IF_ID_PACKET            tb_out [3];
  logic [1:0]             rollback = 2'd0;
  logic                   stall = 1'b0;
  logic                   squash = 1'b0;
  logic                   fetch_ready;
  logic [$clog2(DEPTH):0] occupancy;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int next_pc = 0;
  int drained = 0;

  issue_replay_buffer #(.DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .if_packet_0    (tb_in[0]),
    .if_packet_1    (tb_in[1]),
    .if_packet_2    (tb_in[2]),
    .rollback       (rollback),
    .stall          (stall),
    .squash         (squash),
    .fetch_ready    (fetch_ready),
    .id_packet_out_0(tb_out[0]),
    .id_packet_out_1(tb_out[1]),
    .id_packet_out_2(tb_out[2]),
    .occupancy      (occupancy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int acc_f(input int cnt, input int rb);
    if (rb > cnt) return 0;
    return (cnt < 3 - rb) ? cnt : 3 - rb;
  endfunction

  task automatic drive(input int n);
    for (int k = 0; k < 3; k++) begin
      tb_in[k] = '0;
      if (k < n) begin
        tb_in[k].valid = 1'b1;
        tb_in[k].pc    = 32'(next_pc + 4 * k);
        tb_in[k].inst  = 32'(next_pc + 4 * k) ^ 32'h5A5A_0000;
        tb_in[k].npc   = 32'(next_pc + 4 * k + 4);
      end
    end
  endtask

  // One clock of stimulus: check what the DUT presents now, then advance the model across the edge.
  task automatic step(input int n, input int rb, input bit st, input bit sq);
    int  ready, acc, sz, ev, epc;
    bit  byp;
    drive(n);
    rollback = 2'(rb);
    stall    = st;
    squash   = sq;
    #2;
    sz    = exp_q.size();
    ready = (sz <= DEPTH - 3) ? 1 : 0;
    byp   = 1'b0;
`ifdef REPLAY_BUFFER_BYPASS_EN
    byp = (sz == 0) && !sq;
`endif
    $display("step n=%0d rb=%0d stall=%0d squash=%0d occ=%0d", n, rb, st, sq, sz);
    chk("fetch_ready", 64'(fetch_ready), 64'(ready));
    chk("occupancy", 64'(occupancy), 64'(sz));
    for (int k = 0; k < 3; k++) begin
      if (byp) begin
        ev  = (k < n) ? 1 : 0;
        epc = ev ? next_pc + 4 * k : 0;
      end else begin
        ev  = (k < sz) ? 1 : 0;
        epc = ev ? exp_q[k] : 0;
      end
      chk($sformatf("out%0d_valid", k), 64'(tb_out[k].valid), 64'(ev));
      chk($sformatf("out%0d_pc", k), 64'(tb_out[k].pc), 64'(epc));
      chk($sformatf("out%0d_inst", k), 64'(tb_out[k].inst),
          ev ? 64'(32'(epc) ^ 32'h5A5A_0000) : 64'd0);
    end
    if (sq) begin
      exp_q.delete();
    end else if (byp) begin
      acc = st ? 0 : acc_f(n, rb);
      for (int k = acc; k < n; k++) exp_q.push_back(next_pc + 4 * k);
      drained += acc;
      next_pc += 4 * n;
    end else begin
      acc = st ? 0 : acc_f((sz < 3) ? sz : 3, rb);
      for (int k = 0; k < acc; k++) void'(exp_q.pop_front());
      drained += acc;
      if (ready != 0) begin
        for (int k = 0; k < n; k++) exp_q.push_back(next_pc + 4 * k);
        next_pc += 4 * n;
      end
    end
    @(posedge clock);
    #1;
  endtask

  // Asserted a cycle-offset after the edge so the asynchronous clear is observed immediately.
  task automatic do_reset();
    reset = 1'b1;
    drive(3);
    rollback = 2'd0;
    stall    = 1'b0;
    squash   = 1'b0;
    #2;
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_out%0d", k), 64'(tb_out[k].valid), 64'd0);
      chk($sformatf("rst_out%0d_pc", k), 64'(tb_out[k].pc), 64'd0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    next_pc = 0;
    drained = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 3; k++) tb_in[k] = '0;
    #1;
    do_reset();

    // basic enqueue of three then full drain
    step(3, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // six buffered, rollback two accepts only the oldest
    do_reset();
    step(3, 3, 0, 0);
    step(3, 3, 0, 0);
    step(0, 2, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // full rejection held for four cycles, then released
    do_reset();
    step(3, 3, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 3, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // rollback beyond the presented count dequeues nothing
    do_reset();
    step(1, 0, 0, 0);
    step(0, 2, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // fill to DEPTH, enqueue ignored while not ready
    do_reset();
    step(3, 3, 0, 0);
    step(2, 3, 0, 0);
    step(3, 3, 0, 0);
    step(3, 3, 0, 0);
    step(3, 2, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // stall holds head while enqueue proceeds
    do_reset();
    step(3, 3, 0, 0);
    step(3, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // squash with simultaneous enqueue, and squash over stall
    do_reset();
    step(3, 3, 0, 0);
    step(3, 0, 0, 1);
    step(3, 3, 0, 0);
    step(3, 0, 1, 1);
    step(0, 0, 0, 0);

    // reset in the middle of operation, then restart from empty
    step(3, 3, 0, 0);
    step(3, 3, 0, 0);
    do_reset();
    step(3, 0, 0, 0);
    step(0, 0, 0, 0);

    // random stream across pointer wrap
    do_reset();
    for (int cyc = 0; cyc < 600 && drained < 40; cyc++) begin
      int n, rem;
      rem = 40 - next_pc / 4;
      n   = int'($urandom_range(0, 3));
      if (n > rem) n = rem;
      step(n, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'b0);
    end
    chk("stream_drained", 64'(drained), 64'd40);
    chk("stream_fetched", 64'(next_pc), 64'd160);
    step(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
